booth_multiplier_seq: RTL

//   Parametrised, iterative radix-2 Booth multiplier: one add/sub/shift step per clock on a single

---
 rtl/booth_multiplier_seq.sv | 112 +++++++++++
 1 files changed

// File: rtl/booth_multiplier_seq.sv
// Iterative radix-2 Booth multiplier: one add/sub/shift step per clock on a shared adder,
// signed or unsigned operands per transaction, valid/ready on both sides.
module booth_multiplier_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH+1:0]     a_q, a_d;
    logic [WIDTH:0]       m_q, m_d;
    logic [WIDTH:0]       q_q, q_d;
    logic                 q1_q, q1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH+1:0]     m_ext;
    logic [WIDTH+1:0]     a_sum;
    logic                 accept;
    logic                 last_step;

    assign accept    = in_valid && in_ready;
    assign last_step = (state_q == S_RUN) && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            m_q       <= m_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)    state_d = S_RUN;
            S_RUN:   if (last_step) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // Operands carry one extra bit so unsigned values run through the same signed Booth recurrence.
    always_comb begin
        a_d       = a_q;
        m_d       = m_q;
        q_d       = q_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        m_ext     = {m_q[WIDTH], m_q};
        a_sum     = a_q;
        case ({q_q[0], q1_q})
            2'b01:   a_sum = a_q + m_ext;
            2'b10:   a_sum = a_q - m_ext;
            default: a_sum = a_q;
        endcase
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    m_d   = is_signed ? {multiplicand[WIDTH-1], multiplicand} : {1'b0, multiplicand};
                    q_d   = is_signed ? {multiplier[WIDTH-1], multiplier} : {1'b0, multiplier};
                    a_d   = '0;
                    q1_d  = 1'b0;
                    cnt_d = '0;
                end
            end
            S_RUN: begin
                a_d   = {a_sum[WIDTH+1], a_sum[WIDTH+1:1]};
                q_d   = {a_sum[0], q_q[WIDTH:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q + CW'(1);
                if (last_step)
                    product_d = {a_d[WIDTH-2:0], q_d};
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) && !reset;
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        product   = product_q;
    end
endmodule
